ad9833_sweep_seq: RTL and testbench

AD9833_SWEEP_SEQ -- requirements
Module: ad9833_sweep_seq

---
 rtl/ad9833_pkg.sv | 24 ++
 rtl/ad9833_dwell_timer.sv | 28 ++
 rtl/ad9833_sweep_seq.sv | 162 ++++++++++++++++
 tb/tb_ad9833_sweep_seq.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9833_pkg.sv
// Shared state encoding, control word and frequency arithmetic for the AD9833 sweep sequencer.
package ad9833_pkg;

    localparam int          FREQ_W            = 28;
    localparam logic [15:0] AD9833_CTRL_FREQ0 = 16'h2000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_DONE,
        ST_DWELL,
        ST_NEXT
    } state_t;

    // Frequency words wrap modulo 2^28 in either direction.
    function automatic logic [FREQ_W-1:0] freq_add(
        input logic [FREQ_W-1:0] base,
        input logic [FREQ_W-1:0] delta,
        input logic              down
    );
        freq_add = down ? (base - delta) : (base + delta);
    endfunction

endpackage

// File: rtl/ad9833_dwell_timer.sv
// Dwell hold counter: load arms max(load_val,1) counting cycles; expired flags the last one.
// Load takes effect on the next edge; count only advances while the owner holds it high.
module ad9833_dwell_timer #(
    parameter int DWELL_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               count,
    output logic               expired
);

    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_val == '0) ? DWELL_W'(1) : load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - DWELL_W'(1);
        end
    end

    assign expired = (cnt <= DWELL_W'(1));

endmodule

// File: rtl/ad9833_sweep_seq.sv
// Steps the AD9833 FREQ0 word from f_start by f_step, one serial frame per step, dwelling between frames.
// go is held from SEND entry until good_to_reset_go; AD9833_SWEEP_BIDIR_EN turns the one-shot sweep into a continuous up/down sweep.
module ad9833_sweep_seq
    import ad9833_pkg::*;
#(
    parameter int DWELL_W = 32,
    parameter int STEP_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [27:0]        f_start,
    input  logic [27:0]        f_step,
    input  logic [STEP_W-1:0]  n_steps,
    input  logic [DWELL_W-1:0] dwell,
    output logic               go,
    output logic [15:0]        control,
    output logic [27:0]        freq,
    input  logic               good_to_reset_go,
    input  logic               send_complete,
    output logic               busy,
    output logic               done,
    output logic [STEP_W-1:0]  step_idx
);

    state_t             state;
    state_t             state_nxt;
    logic [27:0]        f_step_q;
    logic [STEP_W-1:0]  n_steps_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               abort_q;
    logic               abort_set;
    logic               launch;
    logic               step_up;
    logic               step_dn;
    logic               tmr_load;
    logic               tmr_expired;
`ifdef AD9833_SWEEP_BIDIR_EN
    logic               dir_down;
`endif

    ad9833_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (dwell_q),
        .count    (state == ST_DWELL),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        done      = 1'b0;
        launch    = 1'b0;
        abort_set = 1'b0;
        step_up   = 1'b0;
        step_dn   = 1'b0;
        tmr_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    launch    = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // A frame in flight is never withdrawn; stop only takes effect after it completes.
                go        = 1'b1;
                abort_set = stop;
                if (good_to_reset_go) state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                abort_set = stop;
                if (send_complete) begin
                    if (abort_q || stop) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        tmr_load  = 1'b1;
                        state_nxt = ST_DWELL;
                    end
                end
            end
            ST_DWELL: begin
                if (stop)             state_nxt = ST_IDLE;
                else if (tmr_expired) state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else begin
`ifdef AD9833_SWEEP_BIDIR_EN
                    // Reflect at both ends; a zero-length sweep just resends f_start.
                    state_nxt = ST_SEND;
                    if (n_steps_q != '0) begin
                        if (!dir_down) begin
                            if (step_idx < n_steps_q) step_up = 1'b1;
                            else                      step_dn = 1'b1;
                        end else begin
                            if (step_idx != '0) step_dn = 1'b1;
                            else                step_up = 1'b1;
                        end
                    end
`else
                    if (step_idx < n_steps_q) begin
                        step_up   = 1'b1;
                        state_nxt = ST_SEND;
                    end else begin
                        done      = 1'b1;
                        state_nxt = ST_IDLE;
                    end
`endif
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            freq      <= '0;
            step_idx  <= '0;
            f_step_q  <= '0;
            n_steps_q <= '0;
            dwell_q   <= '0;
            abort_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE)  abort_q <= 1'b0;
            else if (abort_set)    abort_q <= 1'b1;
            if (launch) begin
                freq      <= f_start;
                step_idx  <= '0;
                f_step_q  <= f_step;
                n_steps_q <= n_steps;
                dwell_q   <= dwell;
            end else if (step_up) begin
                freq     <= freq_add(freq, f_step_q, 1'b0);
                step_idx <= step_idx + STEP_W'(1);
            end else if (step_dn) begin
                freq     <= freq_add(freq, f_step_q, 1'b1);
                step_idx <= step_idx - STEP_W'(1);
            end
        end
    end

`ifdef AD9833_SWEEP_BIDIR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  dir_down <= 1'b0;
        else if (launch)             dir_down <= 1'b0;
        else if (step_up || step_dn) dir_down <= step_dn;
    end
`endif

    assign busy    = (state != ST_IDLE);
    assign control = AD9833_CTRL_FREQ0;

endmodule

// File: tb/tb_ad9833_sweep_seq.sv
// Scoreboard bench for ad9833_sweep_seq: a serial-interface model answers go, a monitor checks every frame and done pulse.
`timescale 1ns/1ps
module tb_ad9833_sweep_seq;

    localparam int DWELL_W = 32;
    localparam int STEP_W  = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [27:0]        f_start = '0;
    logic [27:0]        f_step = '0;
    logic [STEP_W-1:0]  n_steps = '0;
    logic [DWELL_W-1:0] dwell = '0;
    logic               good_to_reset_go = 1'b0;
    logic               send_complete = 1'b0;
    logic               go;
    logic [15:0]        control;
    logic [27:0]        freq;
    logic               busy;
    logic               done;
    logic [STEP_W-1:0]  step_idx;

    ad9833_sweep_seq #(
        .DWELL_W (DWELL_W),
        .STEP_W  (STEP_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .stop             (stop),
        .f_start          (f_start),
        .f_step           (f_step),
        .n_steps          (n_steps),
        .dwell            (dwell),
        .go               (go),
        .control          (control),
        .freq             (freq),
        .good_to_reset_go (good_to_reset_go),
        .send_complete    (send_complete),
        .busy             (busy),
        .done             (done),
        .step_idx         (step_idx)
    );

    always #5 clk = ~clk;

    // Expected frame: frequency, index, and cycles since the last start/send_complete (gap<=0: unchecked).
    typedef struct {
        logic [27:0] f;
        int          idx;
        int          gap;
    } frame_t;

    frame_t exp_q[$];
    int     done_q[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     evt_cyc = 0;
    int     go_cnt = 0;
    int     sc_cnt = 0;
    int     done_cnt = 0;
    int     ack_fix = -1;
    int     cmpl_fix = -1;
    logic   mon_go_q = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with nothing expected", name);
    endtask

    // Reference: frame k of a sweep holds index tri(k) and frequency f_start + index*f_step mod 2^28.
    function automatic int sweep_idx(input int k, input int n, input bit bidir);
        int p;
        if (!bidir || n == 0) return (bidir ? 0 : k);
        p = k % (2 * n);
        return (p <= n) ? p : (2 * n - p);
    endfunction

    function automatic logic [27:0] sweep_freq(input logic [27:0] fs, input logic [27:0] st, input int idx);
        longint v;
        v = (longint'(fs) + longint'(idx) * longint'(st)) % (longint'(1) << 28);
        return 28'(v);
    endfunction

    task automatic expect_frames(input logic [27:0] fs, input logic [27:0] st, input int n,
                                 input int dw, input int count, input bit bidir, input bit with_done);
        frame_t e;
        int     hold;
        hold = (dw < 1) ? 1 : dw;
        for (int k = 0; k < count; k++) begin
            e.idx = sweep_idx(k, n, bidir);
            e.f   = sweep_freq(fs, st, e.idx);
            e.gap = (k == 0) ? 1 : hold + 2;
            exp_q.push_back(e);
        end
        if (with_done) done_q.push_back(hold + 1);
    endtask

    task automatic pulse_start(input logic [27:0] fs, input logic [27:0] st, input int n, input int dw);
        @(negedge clk);
        f_start = fs;
        f_step  = st;
        n_steps = STEP_W'(n);
        dwell   = DWELL_W'(dw);
        start   = 1'b1;
        evt_cyc = cyc;
        @(negedge clk);
        start   = 1'b0;
        f_start = 28'($urandom);
        f_step  = 28'($urandom);
        dwell   = DWELL_W'($urandom_range(0, 50));
    endtask

    task automatic wait_idle(input int budget, input bit poke);
        int i;
        i = 0;
        while (busy && i < budget) begin
            @(negedge clk);
            i++;
            if (poke && i == 2 && busy) begin
                start   = 1'b1;
                f_start = 28'($urandom);
                n_steps = STEP_W'($urandom_range(0, 7));
            end
            if (i == 3) start = 1'b0;
        end
        start = 1'b0;
        check("idle_reached", busy, 0);
    endtask

    task automatic drain_check(input string name);
        check({name, "_frames_left"}, exp_q.size(), 0);
        check({name, "_done_left"}, done_q.size(), 0);
        exp_q.delete();
        done_q.delete();
    endtask

    initial forever @(posedge clk) cyc++;

    initial begin : monitor
        frame_t e;
        int     g;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_go_q = 1'b0;
            end else begin
                if (go && !mon_go_q) begin
                    go_cnt++;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_go");
                    end else begin
                        e = exp_q.pop_front();
                        check("go_freq", freq, e.f);
                        check("go_step_idx", step_idx, e.idx);
                        check("go_control", control, 16'h2000);
                        if (e.gap > 0) check("go_gap", cyc - evt_cyc, e.gap);
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (done_q.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        g = done_q.pop_front();
                        check("done_gap", cyc - evt_cyc, g);
                    end
                end
                mon_go_q = go;
            end
        end
    end

    // Serial-interface model: ack after a delay, then finish the frame a little later.
    initial begin : serial_if
        int          d;
        bit          aborted;
        logic [27:0] fr;
        forever begin
            @(negedge clk);
            if (rst_n && go) begin
                aborted = 1'b0;
                fr = freq;
                d = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
                for (int i = 0; i < d && !aborted; i++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    else check("go_held", go, 1);
                end
                if (!aborted) begin
                    good_to_reset_go = 1'b1;
                    @(negedge clk);
                    good_to_reset_go = 1'b0;
                    if (!rst_n) aborted = 1'b1;
                    else check("go_dropped", go, 0);
                end
                d = (cmpl_fix >= 0) ? cmpl_fix : int'($urandom_range(1, 4));
                for (int i = 0; i < d && !aborted; i++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    else check("freq_stable", freq, fr);
                end
                if (!aborted) begin
                    send_complete = 1'b1;
                    evt_cyc = cyc;
                    sc_cnt++;
                    @(negedge clk);
                    send_complete = 1'b0;
                end
                good_to_reset_go = 1'b0;
                send_complete    = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : stim
        int base_go;
        int base_sc;
        int base_done;
        int i;
        logic [27:0] fs;
        logic [27:0] st;
        int n;
        int dw;

        // Reset state
        #12;
        check("rst_go", go, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_freq", freq, 0);
        check("rst_step_idx", step_idx, 0);
        check("rst_control", control, 16'h2000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // stop beats start in IDLE
        start = 1'b1;
        stop  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stop_over_start_busy", busy, 0);
        end
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        check("stop_over_start_go", go_cnt, 0);

        // stop one cycle after go, slow ack: frame completes, no done, no more frames
        ack_fix   = 4;
        base_go   = go_cnt;
        base_done = done_cnt;
        expect_frames(28'h0000400, 28'h0000020, 3, 3, 1, 1'b0, 1'b0);
        pulse_start(28'h0000400, 28'h0000020, 3, 3);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(200, 1'b0);
        repeat (20) @(negedge clk);
        check("stop_send_go_count", go_cnt - base_go, 1);
        check("stop_send_no_done", done_cnt - base_done, 0);
        drain_check("stop_send");
        ack_fix = -1;

        // stop during dwell after the second frame
        base_sc   = sc_cnt;
        base_done = done_cnt;
        expect_frames(28'h0123456, 28'h0000777, 3, 20, 2, 1'b0, 1'b0);
        pulse_start(28'h0123456, 28'h0000777, 3, 20);
        i = 0;
        while (sc_cnt < base_sc + 2 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("stop_dwell_reached", sc_cnt - base_sc, 2);
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_dwell_idle", busy, 0);
        repeat (5) @(negedge clk);
        check("stop_dwell_no_done", done_cnt - base_done, 0);
        drain_check("stop_dwell");

        // asynchronous reset while waiting for send_complete
        cmpl_fix = 30;
        expect_frames(28'h0AAAAAA, 28'h0000100, 2, 2, 1, 1'b0, 1'b0);
        pulse_start(28'h0AAAAAA, 28'h0000100, 2, 2);
        i = 0;
        while (!(busy && !go) && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("wait_done_reached", busy && !go, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_go", go, 0);
        check("arst_busy", busy, 0);
        check("arst_freq", freq, 0);
        check("arst_step_idx", step_idx, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmpl_fix = -1;
        drain_check("arst");
        repeat (2) @(negedge clk);

`ifdef AD9833_SWEEP_BIDIR_EN
        // Up/down sweep: indices 0,1,2,1,0,1 then stop; never done
        base_go   = go_cnt;
        base_done = done_cnt;
        expect_frames(28'h0000200, 28'h0000040, 2, 2, 6, 1'b1, 1'b0);
        pulse_start(28'h0000200, 28'h0000040, 2, 2);
        i = 0;
        while (go_cnt < base_go + 6 && i < 500) begin
            @(negedge clk);
            i++;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(100, 1'b0);
        check("bidir_go_count", go_cnt - base_go, 6);
        check("bidir_no_done", done_cnt - base_done, 0);
        drain_check("bidir");

        for (int t = 0; t < 3; t++) begin
            fs = 28'($urandom);
            st = 28'($urandom);
            n  = int'($urandom_range(0, 3));
            dw = int'($urandom_range(0, 3));
            base_go = go_cnt;
            expect_frames(fs, st, n, dw, 7, 1'b1, 1'b0);
            pulse_start(fs, st, n, dw);
            i = 0;
            while (go_cnt < base_go + 7 && i < 500) begin
                @(negedge clk);
                i++;
            end
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            wait_idle(100, 1'b0);
            check("bidir_rand_go_count", go_cnt - base_go, 7);
            drain_check("bidir_rand");
        end
`else
        // Basic sweep 100,110,120,130 with fixed 2-cycle ack
        ack_fix   = 2;
        base_done = done_cnt;
        expect_frames(28'h100, 28'h10, 3, 5, 4, 1'b0, 1'b1);
        pulse_start(28'h100, 28'h10, 3, 5);
        wait_idle(500, 1'b0);
        check("basic_done_once", done_cnt - base_done, 1);
        drain_check("basic");
        ack_fix = -1;

        // Wrap past 2^28
        expect_frames(28'hFFFFFF8, 28'h10, 1, 2, 2, 1'b0, 1'b1);
        pulse_start(28'hFFFFFF8, 28'h10, 1, 2);
        wait_idle(500, 1'b0);
        drain_check("wrap");

        // Zero steps, zero dwell: one frame, one-cycle dwell, done
        base_go   = go_cnt;
        base_done = done_cnt;
        expect_frames(28'h0ABCDEF, 28'h1, 0, 0, 1, 1'b0, 1'b1);
        pulse_start(28'h0ABCDEF, 28'h1, 0, 0);
        wait_idle(500, 1'b0);
        check("zero_go_count", go_cnt - base_go, 1);
        check("zero_done_once", done_cnt - base_done, 1);
        drain_check("zero");

        // Random sweeps with a start pulse injected mid-sweep
        for (int t = 0; t < 8; t++) begin
            fs = 28'($urandom);
            st = 28'($urandom);
            n  = int'($urandom_range(0, 4));
            dw = int'($urandom_range(0, 3));
            base_done = done_cnt;
            expect_frames(fs, st, n, dw, n + 1, 1'b0, 1'b1);
            pulse_start(fs, st, n, dw);
            wait_idle(1000, 1'b1);
            check("rand_done_once", done_cnt - base_done, 1);
            drain_check("rand");
        end
`endif

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
